// File: rtl/alu.sv
// alu: 32-bit datapath ALU with zero flag and a registered ALUOut holding stage
module alu (
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [2:0]  ALUop,
  output logic [31:0] ALUResult,
  output logic        Zero,
  input  logic        clk,
  output logic [31:0] ALUOut,
  input  logic        rst_n
);
  logic [31:0] b_sel, sum, aluout_d, aluout_q;
  logic        slt;
  // ALUop[2] inverts B and supplies the +1 carry-in, so one adder serves ADD, SUB and SLT
  always_comb begin
    b_sel    = ALUop[2] ? ~SrcB : SrcB;
    sum      = SrcA + b_sel + {31'b0, ALUop[2]};
    slt      = (SrcA[31] != SrcB[31]) ? SrcA[31] : sum[31];
    aluout_d = (ALUop[1:0] == 2'b00) ? (SrcA & b_sel) :
               (ALUop[1:0] == 2'b01) ? (SrcA | b_sel) :
               (ALUop[1:0] == 2'b10) ? sum :
               ALUop[2] ? {31'b0, slt} : (SrcA ^ SrcB);
  end
  // ALUOut captures the settled result every edge; reset clears it immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) aluout_q <= 32'h0;
    else        aluout_q <= aluout_d;
  end
  assign ALUResult = aluout_d;
  assign Zero      = (aluout_d == 32'h0);
  assign ALUOut    = aluout_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vector and sequence checks for alu
module tb_alu;
  logic [31:0] SrcA, SrcB, ALUResult, ALUOut;
  logic [2:0]  ALUop;
  logic        Zero, clk, rst_n;
  int n_chk, n_fail;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        z;
  } vec_t;
  vec_t vecs[15];

  alu dut (
    .SrcA(SrcA), .SrcB(SrcB), .ALUop(ALUop), .ALUResult(ALUResult),
    .Zero(Zero), .clk(clk), .ALUOut(ALUOut), .rst_n(rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    vecs[0]  = '{32'd7, 32'd3, 3'b000, 32'd3, 1'b0};
    vecs[1]  = '{32'd7, 32'd3, 3'b001, 32'd7, 1'b0};
    vecs[2]  = '{32'd7, 32'd3, 3'b011, 32'd4, 1'b0};
    vecs[3]  = '{32'd7, 32'd3, 3'b100, 32'd4, 1'b0};
    vecs[4]  = '{32'd7, 32'd3, 3'b101, 32'hFFFF_FFFF, 1'b0};
    vecs[5]  = '{32'd7, 32'd3, 3'b010, 32'd10, 1'b0};
    vecs[6]  = '{32'd7, 32'd3, 3'b110, 32'd4, 1'b0};
    vecs[7]  = '{32'h1234_5678, 32'h1234_5678, 3'b110, 32'h0, 1'b1};
    vecs[8]  = '{32'hFFFF_FFFF, 32'h1, 3'b010, 32'h0, 1'b1};
    vecs[9]  = '{32'h0, 32'h1, 3'b110, 32'hFFFF_FFFF, 1'b0};
    vecs[10] = '{32'hFFFF_FFFF, 32'h1, 3'b111, 32'h1, 1'b0};
    vecs[11] = '{32'h1, 32'hFFFF_FFFF, 3'b111, 32'h0, 1'b1};
    vecs[12] = '{32'd5, 32'd5, 3'b111, 32'h0, 1'b1};
    vecs[13] = '{32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 32'h1, 1'b0};
    vecs[14] = '{32'h8000_0000, 32'h1, 3'b111, 32'h1, 1'b0};
    rst_n = 1'b0;
    SrcA = 32'd7;
    SrcB = 32'd3;
    ALUop = 3'b010;
    #12;
    check("reset_aluout", ALUOut, 32'h0);
    check("reset_live_result", ALUResult, 32'd10);
    for (int i = 0; i < 15; i++) begin
      SrcA = vecs[i].a;
      SrcB = vecs[i].b;
      ALUop = vecs[i].op;
      #1;
      check($sformatf("vec%0d_result", i), ALUResult, vecs[i].res);
      check($sformatf("vec%0d_zero", i), {31'b0, Zero}, {31'b0, vecs[i].z});
    end
    @(posedge clk);
    #1;
    check("reset_hold_over_edge", ALUOut, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    SrcA = 32'd7;
    SrcB = 32'd3;
    ALUop = 3'b000;
    #1;
    check("no_capture_before_edge", ALUOut, 32'h0);
    @(posedge clk);
    #1;
    check("seq_and", ALUOut, 32'd3);
    @(negedge clk);
    ALUop = 3'b001;
    @(posedge clk);
    #1;
    check("seq_or", ALUOut, 32'd7);
    @(negedge clk);
    ALUop = 3'b010;
    @(posedge clk);
    #1;
    check("seq_add", ALUOut, 32'd10);
    @(negedge clk);
    ALUop = 3'b110;
    @(posedge clk);
    #1;
    check("seq_sub", ALUOut, 32'd4);
    @(negedge clk);
    ALUop = 3'b010;
    @(posedge clk);
    #1;
    check("load_ten", ALUOut, 32'd10);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_clears", ALUOut, 32'h0);
    check("async_reset_live", ALUResult, 32'd10);
    @(posedge clk);
    #1;
    check("reset_low_hold", ALUOut, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ALUop = 3'b001;
    #1;
    check("release_no_update", ALUOut, 32'h0);
    @(posedge clk);
    #1;
    check("release_first_capture", ALUOut, 32'd7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
